// File: rtl/ysyx_23060240_mem_arbiter.sv
// Two-master (IFU, LSU) to one-slave memory arbiter.
// One transaction in flight; slave silence is bounded by a timeout.
module ysyx_23060240_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_req_addr,
  output logic            ifu_resp_valid,
  input  logic            ifu_resp_ready,
  output logic [DW-1:0]   ifu_resp_rdata,
  output logic            ifu_resp_err,
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic [AW-1:0]   lsu_req_addr,
  input  logic            lsu_req_wen,
  input  logic [DW-1:0]   lsu_req_wdata,
  input  logic [DW/8-1:0] lsu_req_wstrb,
  output logic            lsu_resp_valid,
  input  logic            lsu_resp_ready,
  output logic [DW-1:0]   lsu_resp_rdata,
  output logic            lsu_resp_err,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_req_addr,
  output logic            mem_req_wen,
  output logic [DW-1:0]   mem_req_wdata,
  output logic [DW/8-1:0] mem_req_wstrb,
  input  logic            mem_resp_valid,
  output logic            mem_resp_ready,
  input  logic [DW-1:0]   mem_resp_rdata,
  output logic            busy,
  output logic            owner
);

  localparam int CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TLIM =
    (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] CLIM = CW'(TLIM);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR
  } state_t;

  state_t        state;
  logic          owner_q;
  logic [CW-1:0] cnt;

  logic          idle;
  logic          in_wait;
  logic          in_err;
  logic          sel;
  logic          own_ready;
  logic          own_valid;
  logic          own_err;
  logic [DW-1:0] own_rdata;

  assign idle    = (state == S_IDLE);
  assign in_wait = (state == S_WAIT);
  assign in_err  = (state == S_ERR);
  assign sel     = lsu_req_valid;

  // Grant is combinational so a request is taken the cycle the slave is ready.
  assign mem_req_valid =
    !rst && idle && (lsu_req_valid || ifu_req_valid);
  assign mem_req_addr  = sel ? lsu_req_addr : ifu_req_addr;
  assign mem_req_wen   = sel && lsu_req_wen;
  assign mem_req_wdata = sel ? lsu_req_wdata : '0;
  assign mem_req_wstrb = sel ? lsu_req_wstrb : '0;

  assign lsu_req_ready =
    !rst && idle && sel && mem_req_ready;
  assign ifu_req_ready =
    !rst && idle && !sel && mem_req_ready;

  assign own_ready =
    owner_q ? lsu_resp_ready : ifu_resp_ready;
  assign own_valid =
    !rst && ((in_wait && mem_resp_valid) || in_err);
  assign own_err   = !rst && in_err;
  assign own_rdata =
    (!rst && in_wait && mem_resp_valid) ?
    mem_resp_rdata : '0;

  assign ifu_resp_valid = own_valid && !owner_q;
  assign ifu_resp_err   = own_err && !owner_q;
  assign ifu_resp_rdata = owner_q ? '0 : own_rdata;
  assign lsu_resp_valid = own_valid && owner_q;
  assign lsu_resp_err   = own_err && owner_q;
  assign lsu_resp_rdata = owner_q ? own_rdata : '0;

  // Outside WAIT the slave response is always drained.
  assign mem_resp_ready = in_wait ? own_ready : 1'b1;

  assign busy  = !idle;
  assign owner = owner_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      owner_q <= 1'b0;
      cnt     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (mem_req_valid && mem_req_ready) begin
            owner_q <= sel;
            cnt     <= '0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            if (own_ready) state <= S_IDLE;
          end else if (TIMEOUT != 0 && cnt == CLIM) begin
            state <= S_ERR;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_ERR: begin
          if (own_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060240_mem_arbiter.sv
// Directed bench for the memory arbiter with a
// transaction-level reference model checked every cycle.
module tb_ysyx_23060240_mem_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_resp_valid;
  logic        ifu_resp_ready;
  logic [31:0] ifu_resp_rdata;
  logic        ifu_resp_err;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [31:0] lsu_req_wdata;
  logic [3:0]  lsu_req_wstrb;
  logic        lsu_resp_valid;
  logic        lsu_resp_ready;
  logic [31:0] lsu_resp_rdata;
  logic        lsu_resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic        mem_resp_ready;
  logic [31:0] mem_resp_rdata;
  logic        busy;
  logic        owner;

  int checks = 0;
  int errors = 0;

  ysyx_23060240_mem_arbiter #(
    .AW(32), .DW(32), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid),
    .ifu_req_ready(ifu_req_ready),
    .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid),
    .ifu_resp_ready(ifu_resp_ready),
    .ifu_resp_rdata(ifu_resp_rdata),
    .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid),
    .lsu_req_ready(lsu_req_ready),
    .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen),
    .lsu_req_wdata(lsu_req_wdata),
    .lsu_req_wstrb(lsu_req_wstrb),
    .lsu_resp_valid(lsu_resp_valid),
    .lsu_resp_ready(lsu_resp_ready),
    .lsu_resp_rdata(lsu_resp_rdata),
    .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata),
    .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_ready(mem_resp_ready),
    .mem_resp_rdata(mem_resp_rdata),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: is a transfer outstanding, who
  // owns it, how long the slave has been silent, timed out?
  logic m_busy = 1'b0;
  logic m_who  = 1'b0;
  logic m_seen = 1'b0;
  logic m_err  = 1'b0;
  int   m_age  = 0;
  logic o_rdy, o_v, o_e, n_v;
  logic [31:0] o_d, n_d;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_mreqv", {31'd0, mem_req_valid}, 32'd0);
      chk("rst_irdy", {31'd0, ifu_req_ready}, 32'd0);
      chk("rst_lrdy", {31'd0, lsu_req_ready}, 32'd0);
      chk("rst_irv", {31'd0, ifu_resp_valid}, 32'd0);
      chk("rst_lrv", {31'd0, lsu_resp_valid}, 32'd0);
      chk("rst_ierr", {31'd0, ifu_resp_err}, 32'd0);
      chk("rst_lerr", {31'd0, lsu_resp_err}, 32'd0);
      chk("rst_mrr", {31'd0, mem_resp_ready}, 32'd1);
      m_busy <= 1'b0;
      m_err  <= 1'b0;
    end else if (!m_busy) begin
      chk("m_busy", {31'd0, busy}, 32'd0);
      chk("m_mreqv", {31'd0, mem_req_valid},
          {31'd0, lsu_req_valid | ifu_req_valid});
      chk("m_lrdy", {31'd0, lsu_req_ready},
          {31'd0, lsu_req_valid & mem_req_ready});
      chk("m_irdy", {31'd0, ifu_req_ready},
          {31'd0, !lsu_req_valid & mem_req_ready});
      if (lsu_req_valid) begin
        chk("m_addr", mem_req_addr, lsu_req_addr);
        chk("m_wen", {31'd0, mem_req_wen}, {31'd0, lsu_req_wen});
        chk("m_wdata", mem_req_wdata, lsu_req_wdata);
        chk("m_wstrb", {28'd0, mem_req_wstrb}, {28'd0, lsu_req_wstrb});
      end else if (ifu_req_valid) begin
        chk("m_addr", mem_req_addr, ifu_req_addr);
        chk("m_wen", {31'd0, mem_req_wen}, 32'd0);
        chk("m_wdata", mem_req_wdata, 32'd0);
        chk("m_wstrb", {28'd0, mem_req_wstrb}, 32'd0);
      end
      chk("m_mrr", {31'd0, mem_resp_ready}, 32'd1);
      chk("m_irv", {31'd0, ifu_resp_valid}, 32'd0);
      chk("m_lrv", {31'd0, lsu_resp_valid}, 32'd0);
      chk("m_ird", ifu_resp_rdata, 32'd0);
      chk("m_lrd", lsu_resp_rdata, 32'd0);
      if ((lsu_req_valid | ifu_req_valid) && mem_req_ready) begin
        m_busy <= 1'b1;
        m_who  <= lsu_req_valid;
        m_age  <= 0;
        m_seen <= 1'b0;
        m_err  <= 1'b0;
      end
    end else begin
      o_rdy = m_who ? lsu_resp_ready : ifu_resp_ready;
      o_v   = m_who ? lsu_resp_valid : ifu_resp_valid;
      o_e   = m_who ? lsu_resp_err : ifu_resp_err;
      o_d   = m_who ? lsu_resp_rdata : ifu_resp_rdata;
      n_v   = m_who ? ifu_resp_valid : lsu_resp_valid;
      n_d   = m_who ? ifu_resp_rdata : lsu_resp_rdata;
      chk("m_busy", {31'd0, busy}, 32'd1);
      chk("m_owner", {31'd0, owner}, {31'd0, m_who});
      chk("m_mreqv", {31'd0, mem_req_valid}, 32'd0);
      chk("m_lrdy", {31'd0, lsu_req_ready}, 32'd0);
      chk("m_irdy", {31'd0, ifu_req_ready}, 32'd0);
      chk("m_nv", {31'd0, n_v}, 32'd0);
      chk("m_nd", n_d, 32'd0);
      if (m_err) begin
        chk("m_ov", {31'd0, o_v}, 32'd1);
        chk("m_oe", {31'd0, o_e}, 32'd1);
        chk("m_od", o_d, 32'd0);
        chk("m_mrr", {31'd0, mem_resp_ready}, 32'd1);
        if (o_rdy) m_busy <= 1'b0;
      end else begin
        chk("m_ov", {31'd0, o_v}, {31'd0, mem_resp_valid});
        chk("m_oe", {31'd0, o_e}, 32'd0);
        chk("m_od", o_d, mem_resp_valid ? mem_resp_rdata : 32'd0);
        chk("m_mrr", {31'd0, mem_resp_ready}, {31'd0, o_rdy});
        m_age <= m_age + 1;
        if (mem_resp_valid) m_seen <= 1'b1;
        if (mem_resp_valid && o_rdy) m_busy <= 1'b0;
        else if (!m_seen && !mem_resp_valid && m_age + 1 == TO)
          m_err <= 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int nb;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ifu_req_valid = 0; ifu_req_addr = 0; ifu_resp_ready = 0;
    lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0;
    lsu_req_wdata = 0; lsu_req_wstrb = 0; lsu_resp_ready = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0;
    step(); step();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_owner", {31'd0, owner}, 32'd0);
    rst = 1'b0;
    step();

    // IFU only
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000;
    mem_req_ready = 1; ifu_resp_ready = 1;
    #2;
    chk("ifu_addr", mem_req_addr, 32'h8000_0000);
    chk("ifu_wen", {31'd0, mem_req_wen}, 32'd0);
    chk("ifu_rdy", {31'd0, ifu_req_ready}, 32'd1);
    nb = 0;
    step();
    ifu_req_valid = 0; mem_req_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      if (busy) nb++;
      chk("ifu_lrv", {31'd0, lsu_resp_valid}, 32'd0);
      chk("ifu_early", {31'd0, ifu_resp_valid}, 32'd0);
      step();
    end
    mem_resp_valid = 1; mem_resp_rdata = 32'h0000_0413;
    #2;
    if (busy) nb++;
    chk("ifu_rdata", ifu_resp_rdata, 32'h0000_0413);
    chk("ifu_err", {31'd0, ifu_resp_err}, 32'd0);
    chk("ifu_rv", {31'd0, ifu_resp_valid}, 32'd1);
    chk("ifu_lrv", {31'd0, lsu_resp_valid}, 32'd0);
    step();
    mem_resp_valid = 0;
    #2;
    if (busy) nb++;
    chk("ifu_busy4", nb, 32'd4);
    step();

    // Simultaneous requests: LSU wins
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0004;
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_1000;
    lsu_req_wen = 1; lsu_req_wdata = 32'hDEAD_BEEF;
    lsu_req_wstrb = 4'hF; mem_req_ready = 1;
    lsu_resp_ready = 1; ifu_resp_ready = 1;
    #2;
    chk("sim_lrdy", {31'd0, lsu_req_ready}, 32'd1);
    chk("sim_irdy", {31'd0, ifu_req_ready}, 32'd0);
    chk("sim_addr", mem_req_addr, 32'h8000_1000);
    chk("sim_wen", {31'd0, mem_req_wen}, 32'd1);
    chk("sim_wdata", mem_req_wdata, 32'hDEAD_BEEF);
    chk("sim_wstrb", {28'd0, mem_req_wstrb}, 32'hF);
    step();
    lsu_req_valid = 0; lsu_req_wen = 0;
    #2;
    chk("sim_owner", {31'd0, owner}, 32'd1);
    chk("sim_irdy2", {31'd0, ifu_req_ready}, 32'd0);
    step();
    mem_resp_valid = 1; mem_resp_rdata = 32'h0;
    #2;
    chk("sim_lrv", {31'd0, lsu_resp_valid}, 32'd1);
    step();
    mem_resp_valid = 0;
    #2;
    chk("sim_igrant", {31'd0, ifu_req_ready}, 32'd1);
    chk("sim_iaddr", mem_req_addr, 32'h8000_0004);
    chk("sim_iwdata", mem_req_wdata, 32'd0);
    step();
    ifu_req_valid = 0; mem_req_ready = 0;
    #2;
    chk("sim_owner0", {31'd0, owner}, 32'd0);
    mem_resp_valid = 1; mem_resp_rdata = 32'h1234_5678;
    #1;
    chk("sim_irdata", ifu_resp_rdata, 32'h1234_5678);
    step();
    mem_resp_valid = 0;
    step();

    // Slave back-pressure
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_2000;
    lsu_req_wen = 0; lsu_req_wdata = 32'h0;
    lsu_req_wstrb = 4'h0;
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0008;
    mem_req_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("bp_v", {31'd0, mem_req_valid}, 32'd1);
      chk("bp_addr", mem_req_addr, 32'h8000_2000);
      chk("bp_lrdy", {31'd0, lsu_req_ready}, 32'd0);
      chk("bp_irdy", {31'd0, ifu_req_ready}, 32'd0);
      step();
    end
    mem_req_ready = 1;
    #2;
    chk("bp_grant", {31'd0, lsu_req_ready}, 32'd1);
    step();
    lsu_req_valid = 0; ifu_req_valid = 0;
    mem_req_ready = 0;
    #2;
    chk("bp_owner", {31'd0, owner}, 32'd1);
    step();
    mem_resp_valid = 1; mem_resp_rdata = 32'hCAFE_F00D;
    #2;
    chk("bp_rdata", lsu_resp_rdata, 32'hCAFE_F00D);
    step();
    mem_resp_valid = 0;
    step();

    // Timeout
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_3000;
    mem_req_ready = 1; lsu_resp_ready = 0;
    #2;
    chk("to_grant", {31'd0, lsu_req_ready}, 32'd1);
    step();
    lsu_req_valid = 0; mem_req_ready = 0;
    for (int k = 1; k <= TO; k++) begin
      #2;
      chk("to_quiet", {31'd0, lsu_resp_valid}, 32'd0);
      step();
    end
    #2;
    chk("to_v", {31'd0, lsu_resp_valid}, 32'd1);
    chk("to_err", {31'd0, lsu_resp_err}, 32'd1);
    chk("to_rdata", lsu_resp_rdata, 32'd0);
    step();
    step();
    mem_resp_valid = 1; mem_resp_rdata = 32'hBAD0_BAD0;
    #2;
    chk("to_drain", {31'd0, mem_resp_ready}, 32'd1);
    chk("to_rdata2", lsu_resp_rdata, 32'd0);
    chk("to_err2", {31'd0, lsu_resp_err}, 32'd1);
    chk("to_irv", {31'd0, ifu_resp_valid}, 32'd0);
    step();
    mem_resp_valid = 0; lsu_resp_ready = 1;
    step();
    lsu_resp_ready = 0;
    #2;
    chk("to_idle", {31'd0, busy}, 32'd0);
    mem_resp_valid = 1; mem_resp_rdata = 32'h7777_7777;
    #1;
    chk("stray_mrr", {31'd0, mem_resp_ready}, 32'd1);
    chk("stray_irv", {31'd0, ifu_resp_valid}, 32'd0);
    chk("stray_lrv", {31'd0, lsu_resp_valid}, 32'd0);
    step();
    mem_resp_valid = 0;
    step();

    // Response stall, then async reset mid-WAIT
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0010;
    mem_req_ready = 1; ifu_resp_ready = 0;
    step();
    ifu_req_valid = 0; mem_req_ready = 0;
    step();
    mem_resp_valid = 1; mem_resp_rdata = 32'h55AA_33CC;
    for (int i = 0; i < 20; i++) begin
      #2;
      chk("st_v", {31'd0, ifu_resp_valid}, 32'd1);
      chk("st_rdata", ifu_resp_rdata, 32'h55AA_33CC);
      chk("st_err", {31'd0, ifu_resp_err}, 32'd0);
      step();
    end
    #2;
    chk("st_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_irv", {31'd0, ifu_resp_valid}, 32'd0);
    mem_resp_valid = 0;
    step();
    rst = 1'b0;
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0020;
    mem_req_ready = 1; ifu_resp_ready = 1;
    #2;
    chk("pr_rdy", {31'd0, ifu_req_ready}, 32'd1);
    step();
    ifu_req_valid = 0; mem_req_ready = 0;
    step();
    mem_resp_valid = 1; mem_resp_rdata = 32'h0010_0073;
    #2;
    chk("pr_rdata", ifu_resp_rdata, 32'h0010_0073);
    step();
    mem_resp_valid = 0;
    #2;
    chk("pr_idle", {31'd0, busy}, 32'd0);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
